wbf_rd_arb: RTL and testbench

//  Round-robin arbiter sharing the single Weight Buffer (WBF) read port among NUM_PORT PE-row requesters.
//  It grants one PE-row read address per WBF address handshake and records the granted port ID in an in-order FIFO.
//  It routes each returning WBF datum to the port at the FIFO head.

---
 rtl/wbf_rd_arb_pkg.sv | 24 ++
 rtl/wbf_rd_arb_if.sv | 56 +++++
 rtl/wbf_rd_arb_id_fifo.sv | 72 +++++++
 rtl/wbf_rd_arb.sv | 148 ++++++++++++++
 tb/tb_wbf_rd_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbf_rd_arb_pkg.sv
// Purpose: shared types, default widths and helpers for the WBF read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wbf_rd_arb_pkg;

    localparam int NUM_PORT_DEF       = 4;
    localparam int DATA_WIDTH_DEF     = 8;
    localparam int WEI_ADDR_WIDTH_DEF = 8;
    localparam int OUT_DEPTH_DEF      = 4;

    localparam int PORT_ID_W = $clog2(NUM_PORT_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wbf_rd_arb_if.sv
// Purpose: bundles the config, PE-row and WBF read channels of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel.
// Ports: slave = arbiter view, master = environment (config, PE rows, WBF) view.
interface wbf_rd_arb_if #(
    parameter int NUM_PORT       = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int WEI_ADDR_WIDTH = 8
);
    logic                                       TOPARB_CfgVld;
    logic [NUM_PORT-1:0]                        TOPARB_CfgMsk;
    logic                                       ARBTOP_CfgRdy;

    logic [NUM_PORT-1:0]                        PERARB_AdrVld;
    logic [NUM_PORT-1:0][WEI_ADDR_WIDTH-1:0]    PERARB_Adr;
    logic [NUM_PORT-1:0]                        ARBPER_AdrRdy;

    logic [NUM_PORT-1:0]                        ARBPER_DatVld;
    logic [NUM_PORT-1:0][DATA_WIDTH-1:0]        ARBPER_Dat;
    logic [NUM_PORT-1:0]                        PERARB_DatRdy;

    logic                                       ARBWBF_AdrVld;
    logic [WEI_ADDR_WIDTH-1:0]                  ARBWBF_Adr;
    logic                                       WBFARB_AdrRdy;

    logic                                       WBFARB_DatVld;
    logic [DATA_WIDTH-1:0]                      WBFARB_Dat;
    logic                                       ARBWBF_DatRdy;

    modport slave (
        input  TOPARB_CfgVld, TOPARB_CfgMsk,
        output ARBTOP_CfgRdy,
        input  PERARB_AdrVld, PERARB_Adr,
        output ARBPER_AdrRdy,
        output ARBPER_DatVld, ARBPER_Dat,
        input  PERARB_DatRdy,
        output ARBWBF_AdrVld, ARBWBF_Adr,
        input  WBFARB_AdrRdy,
        input  WBFARB_DatVld, WBFARB_Dat,
        output ARBWBF_DatRdy
    );

    modport master (
        output TOPARB_CfgVld, TOPARB_CfgMsk,
        input  ARBTOP_CfgRdy,
        output PERARB_AdrVld, PERARB_Adr,
        input  ARBPER_AdrRdy,
        input  ARBPER_DatVld, ARBPER_Dat,
        output PERARB_DatRdy,
        input  ARBWBF_AdrVld, ARBWBF_Adr,
        output WBFARB_AdrRdy,
        output WBFARB_DatVld, WBFARB_Dat,
        input  ARBWBF_DatRdy
    );

endinterface

// File: rtl/wbf_rd_arb_id_fifo.sv
// Purpose: in-order FIFO of granted port IDs, one entry per outstanding WBF read.
// Latency: head visible the cycle after the first push; pop frees an entry next cycle.
// Backpressure: push ignored when full (even with a same-cycle pop), pop ignored when empty.
// Ports: clk/rst_n, push_i+din_i, pop_i, full_o, empty_o, head_o.
module arb_id_fifo
    import wbf_rd_arb_pkg::*;
#(
    parameter int DEPTH = OUT_DEPTH_DEF,
    parameter int W     = PORT_ID_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    // No bypass: a full FIFO refuses the push even when an entry leaves this cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: an entry is only read after it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/wbf_rd_arb.sv
// Purpose: round-robin share of the single WBF read port among NUM_PORT PE rows, in-order data return.
// Latency: 0-cycle grant (request->WBF address combinational); data routed combinationally from WBF.
// Backpressure: WBF AdrRdy and a full ID FIFO stall grants; head port DatRdy stalls WBF data.
// Ports: clk, rst_n (async active-low), bus (wbf_rd_arb_if.slave: config, PE-row addr/data, WBF addr/data).
module wbf_rd_arb
    import wbf_rd_arb_pkg::*;
#(
    parameter int NUM_PORT       = NUM_PORT_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int WEI_ADDR_WIDTH = WEI_ADDR_WIDTH_DEF,
    parameter int OUT_DEPTH      = OUT_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    wbf_rd_arb_if.slave   bus
);
    localparam int IDW = idx_width(NUM_PORT);

    state_e              state_q, state_d;
    logic [NUM_PORT-1:0] mask_q, mask_d;
    logic [IDW-1:0]      ptr_q, ptr_d;

    logic [NUM_PORT-1:0] req;
    logic [IDW-1:0]      grant;
    logic                found;
    logic [IDW-1:0]      cand;
    logic                run;
    logic                adr_vld;
    logic [NUM_PORT-1:0] adr_rdy;
    logic                push, pop;
    logic                full, empty;
    logic [IDW-1:0]      head;
    logic [NUM_PORT-1:0] dat_vld;
    logic                dat_rdy;
    logic                cfg_rdy;

    assign req = bus.PERARB_AdrVld & mask_q;
    assign run = (state_q == RUN);

    // Search upward from the RR pointer with wrap-around; first requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NUM_PORT);
            if (!found && req[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // Address channel: only RUN issues reads, and only while an ID slot is free.
    always_comb begin
        adr_vld = run & found & ~full;
        adr_rdy = '0;
        if (adr_vld && bus.WBFARB_AdrRdy) begin
            adr_rdy[grant] = 1'b1;
        end
    end

    assign push = adr_vld & bus.WBFARB_AdrRdy;

    assign bus.ARBWBF_AdrVld = adr_vld;
    assign bus.ARBWBF_Adr    = adr_vld ? bus.PERARB_Adr[grant] : '0;
    assign bus.ARBPER_AdrRdy = adr_rdy;

    // Pointer moves past the winner only on an accepted address, so a stalled grant holds.
    assign ptr_d = push ? IDW'((int'(grant) + 1) % NUM_PORT) : ptr_q;

    // Data channel: the FIFO head names the port that owns the returning datum.
    // Data with an empty FIFO is a WBF protocol error and is neither routed nor accepted.
    always_comb begin
        dat_vld = '0;
        dat_rdy = 1'b0;
        if (!empty) begin
            dat_vld[head] = bus.WBFARB_DatVld;
            dat_rdy       = bus.PERARB_DatRdy[head];
        end
    end

    assign pop = dat_rdy & bus.WBFARB_DatVld;

    assign bus.ARBPER_DatVld = dat_vld;
    assign bus.ARBWBF_DatRdy = dat_rdy;
    assign bus.ARBPER_Dat    = {NUM_PORT{bus.WBFARB_Dat}};

    // Config FSM: a new mask is only accepted once no reads are outstanding.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cfg_rdy = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_rdy = 1'b1;
                if (bus.TOPARB_CfgVld) begin
                    mask_d  = bus.TOPARB_CfgMsk;
                    state_d = (|bus.TOPARB_CfgMsk) ? RUN : IDLE;
                end
            end
            RUN: begin
                if (bus.TOPARB_CfgVld) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cfg_rdy = empty;
                if (bus.TOPARB_CfgVld && empty) begin
                    mask_d  = bus.TOPARB_CfgMsk;
                    state_d = (|bus.TOPARB_CfgMsk) ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ARBTOP_CfgRdy = cfg_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (IDW)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (grant),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_wbf_rd_arb.sv
module tb_wbf_rd_arb;
    import wbf_rd_arb_pkg::*;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int OD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wbf_rd_arb_if #(.NUM_PORT(NP), .DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW)) bus ();

    wbf_rd_arb #(
        .NUM_PORT(NP), .DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW), .OUT_DEPTH(OD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] sb_port_q [$];
    logic [7:0] sb_dat_q  [$];
    logic [7:0] wbf_q     [$];
    logic [3:0] mon_p;
    logic [7:0] mon_d;

    typedef struct {
        logic [3:0] av;   // PE address valids
        logic       wr;   // WBF AdrRdy
        logic       dv;   // WBF DatVld
        logic [3:0] dr;   // PE data readies
        logic       ewv;  // expected ARBWBF_AdrVld
        logic [3:0] epr;  // expected ARBPER_AdrRdy
        int         gp;   // expected granted port (when ewv)
        logic [3:0] edv;  // expected ARBPER_DatVld
        logic       edr;  // expected ARBWBF_DatRdy
    } vec_t;

    vec_t vq [$];

    function automatic logic [7:0] port_adr(input int p);
        return 8'h40 + 8'(p);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] av, input logic wr, input logic dv, input logic [3:0] dr);
        bus.PERARB_AdrVld = av;
        bus.WBFARB_AdrRdy = wr;
        bus.WBFARB_DatVld = dv;
        bus.PERARB_DatRdy = dr;
        bus.WBFARB_Dat    = (wbf_q.size() > 0) ? (wbf_q[0] ^ 8'hA5) : 8'h00;
    endtask

    task automatic sb_push(input int p);
        sb_port_q.push_back(4'(p));
        sb_dat_q.push_back(port_adr(p) ^ 8'hA5);
    endtask

    // One cycle in which port gp must win and be accepted by the WBF.
    task automatic grant_cycle(input logic [3:0] av, input int gp);
        drive(av, 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        chk("grant_wbf_vld", bus.ARBWBF_AdrVld, 1'b1);
        chk("grant_per_rdy", bus.ARBPER_AdrRdy, 4'b0001 << gp);
        chk("grant_adr", bus.ARBWBF_Adr, port_adr(gp));
        sb_push(gp);
        tick();
    endtask

    task automatic row(input logic [3:0] av, input logic wr, input logic dv, input logic [3:0] dr,
                       input logic ewv, input logic [3:0] epr, input int gp,
                       input logic [3:0] edv, input logic edr);
        vec_t v;
        v = '{av, wr, dv, dr, ewv, epr, gp, edv, edr};
        vq.push_back(v);
    endtask

    // WBF model plus data scoreboard: the WBF returns addr^A5 in order; every data
    // handshake must land on the port predicted when the address was granted.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.ARBWBF_AdrVld && bus.WBFARB_AdrRdy) begin
                wbf_q.push_back(bus.ARBWBF_Adr);
            end
            if (bus.WBFARB_DatVld && bus.ARBWBF_DatRdy) begin
                if (wbf_q.size() > 0) begin
                    void'(wbf_q.pop_front());
                end
                if (sb_port_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_pop: got DatVld=%b expected no data handshake", bus.ARBPER_DatVld);
                end else begin
                    mon_p = sb_port_q.pop_front();
                    mon_d = sb_dat_q.pop_front();
                    chk("sb_dat_port", bus.ARBPER_DatVld, 4'b0001 << mon_p);
                    chk("sb_dat_val", bus.ARBPER_Dat[mon_p], mon_d);
                end
            end
        end
    end

    initial begin
        bus.TOPARB_CfgVld = 1'b0;
        bus.TOPARB_CfgMsk = '0;
        for (int p = 0; p < NP; p++) bus.PERARB_Adr[p] = port_adr(p);
        drive(4'h0, 1'b0, 1'b0, 4'h0);

        // Reset state.
        #12;
        chk("rst_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b1);
        chk("rst_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
        chk("rst_per_rdy", bus.ARBPER_AdrRdy, 4'h0);
        chk("rst_dat_vld", bus.ARBPER_DatVld, 4'h0);
        chk("rst_dat_rdy", bus.ARBWBF_DatRdy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Configure all four ports.
        bus.TOPARB_CfgVld = 1'b1;
        bus.TOPARB_CfgMsk = 4'b1111;
        @(negedge clk);
        chk("cfg_rdy_idle", bus.ARBTOP_CfgRdy, 1'b1);
        tick();
        bus.TOPARB_CfgVld = 1'b0;
        @(negedge clk);
        chk("cfg_rdy_run", bus.ARBTOP_CfgRdy, 1'b0);
        tick();

        //   av     wr    dv    dr     ewv   epr      gp  edv      edr
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0001, 0, 4'b0000, 1'b0); // RR sweep 0..3,0
        row(4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 1, 4'b0001, 1'b1);
        row(4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 2, 4'b0010, 1'b1);
        row(4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b1000, 3, 4'b0100, 1'b1);
        row(4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 0, 4'b1000, 1'b1);
        row(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b0001, 1'b1);
        row(4'hF, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 1, 4'b0000, 1'b0); // WBF stall holds grant
        row(4'hF, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 1, 4'b0000, 1'b0);
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0010, 1, 4'b0000, 1'b0); // fill FIFO
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0100, 2, 4'b0000, 1'b1);
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b1000, 3, 4'b0000, 1'b1);
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0001, 0, 4'b0000, 1'b1);
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 4'b0000, 0, 4'b0000, 1'b1); // full
        row(4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b0010, 1'b1); // full + pop: no bypass
        row(4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0010, 1, 4'b0000, 1'b1);
        row(4'h0, 1'b1, 1'b1, 4'hB, 1'b0, 4'b0000, 0, 4'b0100, 1'b0); // head 2 not ready
        row(4'h0, 1'b1, 1'b1, 4'hB, 1'b0, 4'b0000, 0, 4'b0100, 1'b0);
        row(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b0100, 1'b1);
        row(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b1000, 1'b1);
        row(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b0001, 1'b1);
        row(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b0010, 1'b1);
        row(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0000, 0, 4'b0000, 1'b0); // data with empty FIFO

        foreach (vq[i]) begin
            drive(vq[i].av, vq[i].wr, vq[i].dv, vq[i].dr);
            @(negedge clk);
            chk($sformatf("v%0d_wbf_vld", i), bus.ARBWBF_AdrVld, vq[i].ewv);
            chk($sformatf("v%0d_per_rdy", i), bus.ARBPER_AdrRdy, vq[i].epr);
            if (vq[i].ewv) chk($sformatf("v%0d_adr", i), bus.ARBWBF_Adr, port_adr(vq[i].gp));
            chk($sformatf("v%0d_dat_vld", i), bus.ARBPER_DatVld, vq[i].edv);
            chk($sformatf("v%0d_dat_rdy", i), bus.ARBWBF_DatRdy, vq[i].edr);
            if (vq[i].ewv && vq[i].wr) sb_push(vq[i].gp);
            tick();
        end

        // Reconfigure during RUN with three reads outstanding.
        grant_cycle(4'hF, 2);
        grant_cycle(4'hF, 3);
        grant_cycle(4'hF, 0);
        bus.TOPARB_CfgVld = 1'b1;
        bus.TOPARB_CfgMsk = 4'b1000;
        drive(4'h0, 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        chk("run_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b0);
        tick();
        drive(4'hF, 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        chk("drain_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
        chk("drain_per_rdy", bus.ARBPER_AdrRdy, 4'h0);
        chk("drain_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 1'b1, 1'b1, 4'hF);
            @(negedge clk);
            chk("drain_pop_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b0);
            chk("drain_pop_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
            tick();
        end
        drive(4'hF, 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        chk("drained_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b1);
        chk("drained_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
        tick();
        bus.TOPARB_CfgVld = 1'b0;
        grant_cycle(4'hF, 3);
        grant_cycle(4'hF, 3);
        for (int k = 0; k < 2; k++) begin
            drive(4'h0, 1'b1, 1'b1, 4'hF);
            @(negedge clk);
            chk("m8_dat_vld", bus.ARBPER_DatVld, 4'b1000);
            tick();
        end

        // Sparse mask 0101.
        bus.TOPARB_CfgVld = 1'b1;
        bus.TOPARB_CfgMsk = 4'b0101;
        drive(4'h0, 1'b1, 1'b0, 4'hF);
        tick();
        @(negedge clk);
        chk("m5_cfg_rdy_drain", bus.ARBTOP_CfgRdy, 1'b1);
        tick();
        bus.TOPARB_CfgVld = 1'b0;
        drive(4'b1010, 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        chk("m5_masked_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
        chk("m5_masked_per_rdy", bus.ARBPER_AdrRdy, 4'h0);
        tick();
        grant_cycle(4'b1110, 2);
        drive(4'h0, 1'b1, 1'b1, 4'hF);
        @(negedge clk);
        chk("m5_dat_vld", bus.ARBPER_DatVld, 4'b0100);
        tick();
        grant_cycle(4'hF, 0);
        drive(4'h0, 1'b1, 1'b1, 4'hF);
        tick();

        // Async reset with two reads outstanding.
        grant_cycle(4'b0100, 2);
        grant_cycle(4'b0100, 2);
        drive(4'hF, 1'b1, 1'b1, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b1);
        chk("arst_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
        chk("arst_per_rdy", bus.ARBPER_AdrRdy, 4'h0);
        chk("arst_dat_vld", bus.ARBPER_DatVld, 4'h0);
        chk("arst_dat_rdy", bus.ARBWBF_DatRdy, 1'b0);
        sb_port_q.delete();
        sb_dat_q.delete();
        wbf_q.delete();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(4'hF, 1'b1, 1'b1, 4'hF);
        @(negedge clk);
        chk("post_rst_cfg_rdy", bus.ARBTOP_CfgRdy, 1'b1);
        chk("post_rst_wbf_vld", bus.ARBWBF_AdrVld, 1'b0);
        chk("post_rst_dat_vld", bus.ARBPER_DatVld, 4'h0);
        chk("post_rst_dat_rdy", bus.ARBWBF_DatRdy, 1'b0);
        bus.TOPARB_CfgVld = 1'b1;
        bus.TOPARB_CfgMsk = 4'b1111;
        tick();
        bus.TOPARB_CfgVld = 1'b0;
        grant_cycle(4'hF, 0);
        drive(4'h0, 1'b1, 1'b1, 4'hF);
        tick();
        drive(4'h0, 1'b0, 1'b0, 4'hF);
        tick();

        chk("sb_empty", sb_port_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
